// File: rtl/uart_pkg.sv
// uart_pkg: shared parity codes, error bit indices, FSM encodings and clog2 helper
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    localparam int ERR_P = 0;
    localparam int ERR_F = 1;
    localparam int ERR_O = 2;
    typedef enum logic [2:0] {TX_S_IDLE, TX_S_START, TX_S_DATA, TX_S_PAR, TX_S_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_S_IDLE, RX_S_START, RX_S_DATA, RX_S_PAR, RX_S_STOP, RX_S_BREAK} rx_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through synchronous FIFO
//   clk/rst: clock, async active-high reset; push/din: write unless full;
//   pop: drop head unless empty; dout: current head; full/empty: registered-pointer flags
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int Aw = clog2(Depth);
    logic [Width-1:0] mem [Depth];
    logic [Aw:0] wp, rp;
    logic do_push, do_pop;
    // extra pointer MSB tells a full ring apart from an empty one
    assign empty = wp == rp;
    assign full = wp[Aw] != rp[Aw] && wp[Aw-1:0] == rp[Aw-1:0];
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rp[Aw-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (Aw+1)'(do_push);
            rp <= rp + (Aw+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp[Aw-1:0]] <= din;
endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX/RX FIFOs, parity, multi-bit stop and sticky errors
//   CLK/RST: clock, async active-high reset; RXD/TXD: serial pins
//   DIN/WE/TX_FULL/TX_IDLE: transmit queue; DOUT/RE/RX_EMPTY: receive queue
//   ERR: sticky {OERR, FERR, PERR}, CLR clears it; INT: data waiting or any error
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int Fclk   = 12_000_000,
    parameter int Bauds  = 115_200,
    parameter int Wdata  = 8,
    parameter int Wstop  = 1,
    parameter int Parity = 0,
    parameter int Depth  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RXD,
    output logic             TXD,
    input  logic [Wdata-1:0] DIN,
    input  logic             WE,
    output logic             TX_FULL,
    output logic             TX_IDLE,
    output logic [Wdata-1:0] DOUT,
    input  logic             RE,
    output logic             RX_EMPTY,
    output logic [2:0]       ERR,
    input  logic             CLR,
    output logic             INT
);
    localparam int Div = (Fclk + Bauds / 2) / Bauds;
    localparam int Cw = clog2(Div) + 1;
    localparam int Bw = clog2(Wdata + 2);
    localparam logic [Cw-1:0] DIV_M1 = Cw'(Div - 1);
    localparam logic [Cw-1:0] STOP_M1 = Cw'(Wstop * Div - 1);
    localparam logic [Cw-1:0] HALF = Cw'(Div / 2);
    localparam logic [Bw-1:0] LAST = Bw'(Wdata - 1);
    localparam logic ODD = Parity == PAR_ODD;
    localparam logic HAS_PAR = Parity != PAR_NONE;
    if (Div < 4 || Wdata < 5 || Wdata > 9 || Wstop < 1 || Wstop > 2 ||
        (Parity != PAR_NONE && Parity != PAR_EVEN && Parity != PAR_ODD) ||
        Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_params
        $error("uart_fifo_core: unsupported parameter set");
    end
    tx_state_t ts;
    rx_state_t rs;
    logic [Cw-1:0] tcnt, rcnt;
    logic [Bw-1:0] tbit, rbit;
    logic [Wdata-1:0] tsh, tx_head, rsh;
    logic tpar, tx_empty, tx_pop, ppend, s1, s2, rx_full, rx_push, stop_smp;
    logic [2:0] eset;
    uart_sync_fifo #(.Width(Wdata), .Depth(Depth)) u_tx_fifo (
        .clk(CLK), .rst(RST), .push(WE), .pop(tx_pop), .din(DIN),
        .dout(tx_head), .full(TX_FULL), .empty(tx_empty)
    );
    uart_sync_fifo #(.Width(Wdata), .Depth(Depth)) u_rx_fifo (
        .clk(CLK), .rst(RST), .push(rx_push), .pop(RE), .din(rsh),
        .dout(DOUT), .full(rx_full), .empty(RX_EMPTY)
    );
    // popping at the end of the stop period chains frames with no idle gap
    assign tx_pop = (ts == TX_S_IDLE || (ts == TX_S_STOP && tcnt == '0)) && !tx_empty;
    assign TX_IDLE = ts == TX_S_IDLE && tx_empty;
    assign stop_smp = rs == RX_S_STOP && rcnt == '0;
    assign rx_push = stop_smp && s2 && !rx_full;
    assign INT = !RX_EMPTY || |ERR;
    always_comb begin
        eset = '0;
        eset[ERR_P] = stop_smp && s2 && ppend;
        eset[ERR_F] = stop_smp && !s2;
        eset[ERR_O] = stop_smp && s2 && rx_full;
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            ts <= TX_S_IDLE;
            tcnt <= '0;
            tbit <= '0;
            tsh <= '0;
            tpar <= 1'b0;
            TXD <= 1'b1;
        end else if (tx_pop) begin
            ts <= TX_S_START;
            tcnt <= DIV_M1;
            tsh <= tx_head;
            tpar <= ^tx_head ^ ODD;
            TXD <= 1'b0;
        end else if (ts != TX_S_IDLE && tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
        end else begin
            case (ts)
                TX_S_START: begin
                    ts <= TX_S_DATA;
                    tcnt <= DIV_M1;
                    tbit <= '0;
                    TXD <= tsh[0];
                end
                TX_S_DATA: begin
                    if (tbit == LAST) begin
                        ts <= HAS_PAR ? TX_S_PAR : TX_S_STOP;
                        tcnt <= HAS_PAR ? DIV_M1 : STOP_M1;
                        TXD <= HAS_PAR ? tpar : 1'b1;
                    end else begin
                        tcnt <= DIV_M1;
                        tbit <= tbit + 1'b1;
                        tsh <= tsh >> 1;
                        TXD <= tsh[1];
                    end
                end
                TX_S_PAR: begin
                    ts <= TX_S_STOP;
                    tcnt <= STOP_M1;
                    TXD <= 1'b1;
                end
                default: ts <= TX_S_IDLE;
            endcase
        end
    always_ff @(posedge CLK or posedge RST)
        if (RST) {s2, s1} <= 2'b11;
        else {s2, s1} <= {s1, RXD};
    // only the first stop bit is sampled so a second one can overlap the next start search
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            rs <= RX_S_IDLE;
            rcnt <= '0;
            rbit <= '0;
            rsh <= '0;
            ppend <= 1'b0;
        end else if (rs == RX_S_IDLE) begin
            if (!s2) begin
                rs <= RX_S_START;
                rcnt <= HALF;
            end
        end else if (rs == RX_S_BREAK) begin
            if (s2) rs <= RX_S_IDLE;
        end else if (rcnt != '0) begin
            rcnt <= rcnt - 1'b1;
        end else begin
            rcnt <= DIV_M1;
            case (rs)
                RX_S_START: begin
                    rs <= s2 ? RX_S_IDLE : RX_S_DATA;
                    rbit <= '0;
                    ppend <= 1'b0;
                end
                RX_S_DATA: begin
                    rsh <= {s2, rsh[Wdata-1:1]};
                    rbit <= rbit + 1'b1;
                    if (rbit == LAST) rs <= HAS_PAR ? RX_S_PAR : RX_S_STOP;
                end
                RX_S_PAR: begin
                    ppend <= ^rsh ^ s2 ^ ODD;
                    rs <= RX_S_STOP;
                end
                default: rs <= s2 ? RX_S_IDLE : RX_S_BREAK;
            endcase
        end
    // a new error in the same cycle as CLR survives the clear
    always_ff @(posedge CLK or posedge RST)
        if (RST) ERR <= '0;
        else ERR <= (CLR ? 3'b000 : ERR) | eset;
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: self-checking bench; instances with parity none/even/odd, the odd one looped back
module tb_uart_fifo_core;
    localparam int Div = 12;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] rxd = 2'b11;
    logic [2:0] we = '0;
    logic [2:0] re = '0;
    logic [2:0] clr = '0;
    logic [2:0][7:0] din = '0;
    logic [2:0] txd, tx_full, tx_idle, rx_empty, irq;
    logic [2:0][7:0] dout;
    logic [2:0][2:0] err;
    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic rx_in;
        if (g == 2) begin : g_lb
            assign rx_in = txd[2];
        end else begin : g_ext
            assign rx_in = rxd[g];
        end
        uart_fifo_core #(
            .Fclk(12_000_000), .Bauds(1_000_000), .Wdata(8), .Wstop(1), .Parity(g), .Depth(16)
        ) dut (
            .CLK(clk), .RST(rst), .RXD(rx_in), .TXD(txd[g]), .DIN(din[g]), .WE(we[g]),
            .TX_FULL(tx_full[g]), .TX_IDLE(tx_idle[g]), .DOUT(dout[g]), .RE(re[g]),
            .RX_EMPTY(rx_empty[g]), .ERR(err[g]), .CLR(clr[g]), .INT(irq[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // line level of bit slot p in a no-parity, one-stop frame carrying w
    function automatic logic frame_bit(input logic [7:0] w, input int p);
        return p == 0 ? 1'b0 : p == 9 ? 1'b1 : w[p-1];
    endfunction

    task automatic push(input int g, input logic [7:0] w);
        for (int i = 0; i < 3000 && tx_full[g]; i++) @(negedge clk);
        check("push room", 32'(tx_full[g]), 0);
        din[g] = w;
        we[g] = 1'b1;
        @(negedge clk);
        we[g] = 1'b0;
    endtask

    task automatic pop_check(input int g, input logic [7:0] w);
        check("rx_empty before pop", 32'(rx_empty[g]), 0);
        check("dout", 32'(dout[g]), 32'(w));
        re[g] = 1'b1;
        @(negedge clk);
        re[g] = 1'b0;
    endtask

    task automatic clear(input int g);
        clr[g] = 1'b1;
        @(negedge clk);
        clr[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 3000 && !tx_idle[g]; i++) @(negedge clk);
        check("tx_idle timeout", 32'(tx_idle[g]), 1);
    endtask

    task automatic send_frame(input int g, input logic [7:0] w, input logic par_en,
                              input logic pbit, input logic stop);
        rxd[g] = 1'b0;
        cycles(Div);
        for (int i = 0; i < 8; i++) begin
            rxd[g] = w[i];
            cycles(Div);
        end
        if (par_en) begin
            rxd[g] = pbit;
            cycles(Div);
        end
        rxd[g] = stop;
        cycles(Div);
        rxd[g] = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        logic bad;
        logic pb;
        int n;
        int g;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        for (int k = 0; k < 3; k++) begin
            check("reset txd", 32'(txd[k]), 1);
            check("reset tx_full", 32'(tx_full[k]), 0);
            check("reset tx_idle", 32'(tx_idle[k]), 1);
            check("reset rx_empty", 32'(rx_empty[k]), 1);
            check("reset err", 32'(err[k]), 0);
            check("reset int", 32'(irq[k]), 0);
        end

        push(0, 8'h55);
        check("tx pre-start", 32'(txd[0]), 1);
        push(0, 8'hA3);
        for (int i = 0; i < 240; i++) begin
            check("tx frame bit", 32'(txd[0]), 32'(frame_bit(i < 120 ? 8'h55 : 8'hA3, (i % 120) / 12)));
            if (i == 239) check("tx_idle in last stop", 32'(tx_idle[0]), 0);
            @(negedge clk);
        end
        check("tx_idle after frames", 32'(tx_idle[0]), 1);

        for (int i = 0; i < 16; i++) begin
            push(2, 8'(i));
            exp_q.push_back(8'(i));
        end
        wait_idle(2);
        cycles(4);
        check("loop err after 16", 32'(err[2]), 0);
        check("loop head after 16", 32'(dout[2]), 0);
        push(2, 8'h10);
        wait_idle(2);
        cycles(4);
        check("loop overrun err", 32'(err[2]), 32'(3'b100));
        check("loop overrun int", 32'(irq[2]), 1);
        check("loop head kept", 32'(dout[2]), 0);
        while (exp_q.size() > 0) pop_check(2, exp_q.pop_front());
        check("loop drained", 32'(rx_empty[2]), 1);
        clear(2);
        check("loop clr err", 32'(err[2]), 0);
        check("loop clr int", 32'(irq[2]), 0);

        for (int b = 0; b < 3; b++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                w = 8'($urandom);
                push(2, w);
                exp_q.push_back(w);
            end
            wait_idle(2);
            cycles(4);
            check("rand loop err", 32'(err[2]), 0);
            while (exp_q.size() > 0) pop_check(2, exp_q.pop_front());
            check("rand loop drained", 32'(rx_empty[2]), 1);
        end

        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        cycles(4);
        check("ferr err", 32'(err[0]), 32'(3'b010));
        check("ferr rx_empty", 32'(rx_empty[0]), 1);
        check("ferr int", 32'(irq[0]), 1);
        clear(0);
        check("ferr clr err", 32'(err[0]), 0);
        check("ferr clr int", 32'(irq[0]), 0);

        rxd[0] = 1'b0;
        cycles(4);
        rxd[0] = 1'b1;
        cycles(30);
        check("glitch rx_empty", 32'(rx_empty[0]), 1);
        check("glitch err", 32'(err[0]), 0);

        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        cycles(4);
        check("perr err", 32'(err[1]), 32'(3'b001));
        check("perr rx_empty", 32'(rx_empty[1]), 0);
        pop_check(1, 8'h07);
        clear(1);
        check("perr clr err", 32'(err[1]), 0);

        for (int k = 0; k < 8; k++) begin
            g = k % 2;
            w = 8'($urandom);
            bad = g == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
            pb = (^w) ^ bad;
            send_frame(g, w, g == 1, pb, 1'b1);
            cycles(4);
            check("rand rx err", 32'(err[g]), {31'd0, bad});
            pop_check(g, w);
            clear(g);
            check("rand rx drained", 32'(rx_empty[g]), 1);
            check("rand rx clr", 32'(err[g]), 0);
        end

        push(0, 8'h00);
        cycles(55);
        check("tx data bit 3 low", 32'(txd[0]), 0);
        #2 rst = 1'b1;
        #1 check("reset txd async", 32'(txd[0]), 1);
        check("reset tx_full", 32'(tx_full[0]), 0);
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("post-reset tx_idle", 32'(tx_idle[0]), 1);
        check("post-reset txd", 32'(txd[0]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
